// File: rtl/token_scanner.sv
// Token scanner: walks a byte ROM from address 0, folds decimal digits into
// 16-bit numbers and emits number/operator tokens over a valid/ready port.
// Scanning stops on the '#' end marker, or in ERR on a bad code, on a number
// that does not fit in 16 bits, or on running past address 99.
module token_scanner (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  index,
  input  logic [7:0]  rom_data,
  output logic        tok_valid,
  input  logic        tok_ready,
  output logic        tok_is_op,
  output logic [15:0] tok_value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  tok_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT_NUM,
    EMIT_OP,
    DONE,
    ERR
  } state_t;

  localparam logic [6:0] LAST_INDEX = 7'd99;
  localparam logic [7:0] END_CODE   = 8'd10;
  localparam logic [7:0] OP_FIRST   = 8'd20;
  localparam logic [7:0] OP_LAST    = 8'd23;

  state_t      state, state_nxt;
  logic [6:0]  index_nxt;
  logic [6:0]  count_nxt;
  logic [15:0] acc, acc_nxt;
  logic        have_num, have_num_nxt;
  logic [7:0]  pend_code, pend_code_nxt;
  logic        pend_op, pend_op_nxt;
  logic        pend_end, pend_end_nxt;

  logic        is_digit;
  logic        is_end;
  logic        is_op;
  logic        at_last;
  logic        transfer;
  logic [19:0] acc_wide;

  // Token port and status flags are pure functions of the state, so reset clears them at once
  always_comb begin
    tok_valid = (state == EMIT_NUM) || (state == EMIT_OP);
    tok_is_op = (state == EMIT_OP);
    tok_value = 16'd0;
    if (state == EMIT_NUM) begin
      tok_value = acc;
    end else if (state == EMIT_OP) begin
      tok_value = {8'd0, pend_code};
    end
    busy = (state == FETCH) || (state == EMIT_NUM) || (state == EMIT_OP);
    done = (state == DONE);
    err  = (state == ERR);
  end

  // Classify the ROM byte and form acc*10+digit wide enough to see overflow
  always_comb begin
    is_digit = (rom_data <= 8'd9);
    is_end   = (rom_data == END_CODE);
    is_op    = (rom_data >= OP_FIRST) && (rom_data <= OP_LAST);
    at_last  = (index == LAST_INDEX);
    acc_wide = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {16'd0, rom_data[3:0]};
    transfer = tok_valid && tok_ready;
  end

  // Next-state and datapath updates; every register holds unless a rule below changes it
  always_comb begin
    state_nxt     = state;
    index_nxt     = index;
    count_nxt     = tok_count;
    acc_nxt       = acc;
    have_num_nxt  = have_num;
    pend_code_nxt = pend_code;
    pend_op_nxt   = pend_op;
    pend_end_nxt  = pend_end;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nxt    = FETCH;
          index_nxt    = 7'd0;
          count_nxt    = 7'd0;
          acc_nxt      = 16'd0;
          have_num_nxt = 1'b0;
          pend_op_nxt  = 1'b0;
          pend_end_nxt = 1'b0;
        end
      end
      FETCH: begin
        if (is_digit) begin
          if (at_last || (acc_wide[19:16] != 4'd0)) begin
            state_nxt = ERR;
          end else begin
            acc_nxt      = acc_wide[15:0];
            have_num_nxt = 1'b1;
            index_nxt    = index + 7'd1;
          end
        end else if (is_op) begin
          if (at_last) begin
            state_nxt = ERR;
          end else begin
            pend_code_nxt = rom_data;
            index_nxt     = index + 7'd1;
            if (have_num) begin
              pend_op_nxt = 1'b1;
              state_nxt   = EMIT_NUM;
            end else begin
              state_nxt = EMIT_OP;
            end
          end
        end else if (is_end) begin
          if (have_num) begin
            pend_end_nxt = 1'b1;
            state_nxt    = EMIT_NUM;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          state_nxt = ERR;
        end
      end
      EMIT_NUM: begin
        if (transfer) begin
          acc_nxt      = 16'd0;
          have_num_nxt = 1'b0;
          count_nxt    = tok_count + 7'd1;
          if (pend_op) begin
            pend_op_nxt = 1'b0;
            state_nxt   = EMIT_OP;
          end else begin
            pend_end_nxt = 1'b0;
            state_nxt    = pend_end ? DONE : FETCH;
          end
        end
      end
      EMIT_OP: begin
        if (transfer) begin
          count_nxt = tok_count + 7'd1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      index     <= 7'd0;
      tok_count <= 7'd0;
      acc       <= 16'd0;
      have_num  <= 1'b0;
      pend_code <= 8'd0;
      pend_op   <= 1'b0;
      pend_end  <= 1'b0;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      tok_count <= count_nxt;
      acc       <= acc_nxt;
      have_num  <= have_num_nxt;
      pend_code <= pend_code_nxt;
      pend_op   <= pend_op_nxt;
      pend_end  <= pend_end_nxt;
    end
  end

endmodule

// File: tb/tb_token_scanner.sv
// Bench for token_scanner: a ROM array feeds the scanner, a software scan of
// the same ROM predicts the token stream, and a per-cycle monitor checks
// every transfer, stall stability and the token count against it.
module tb_token_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  index;
  logic [7:0]  rom_data;
  logic        tok_valid;
  logic        tok_ready;
  logic        tok_is_op;
  logic [15:0] tok_value;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  tok_count;

  typedef struct {
    bit is_op;
    int value;
  } tok_t;

  logic [7:0] rom [0:127];
  int         rom_src[$];
  tok_t       exp_q[$];
  bit         exp_err;
  int         exp_index;
  int         exp_tokens;

  int checks   = 0;
  int failures = 0;

  token_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .index     (index),
    .rom_data  (rom_data),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_value (tok_value),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .tok_count (tok_count)
  );

  assign rom_data = rom[index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 128; i++) rom[i] = 8'd10;
    for (int i = 0; i < rom_src.size(); i++) rom[i] = rom_src[i][7:0];
  endtask

  // Software scan of the ROM: which tokens appear, and where and how it stops
  task automatic build_model();
    int   acc;
    bit   have;
    int   i;
    bit   fin;
    int   code;
    tok_t t;
    acc = 0; have = 0; i = 0; fin = 0;
    exp_q.delete();
    exp_err = 0;
    while (!fin) begin
      code = int'(rom[i]);
      if (code <= 9) begin
        if (i == 99 || acc * 10 + code > 65535) begin
          exp_err = 1; fin = 1;
        end else begin
          acc = acc * 10 + code; have = 1; i++;
        end
      end else if (code >= 20 && code <= 23) begin
        if (i == 99) begin
          exp_err = 1; fin = 1;
        end else begin
          if (have) begin
            t.is_op = 0; t.value = acc; exp_q.push_back(t);
          end
          t.is_op = 1; t.value = code; exp_q.push_back(t);
          acc = 0; have = 0; i++;
        end
      end else if (code == 10) begin
        if (have) begin
          t.is_op = 0; t.value = acc; exp_q.push_back(t);
        end
        fin = 1;
      end else begin
        exp_err = 1; fin = 1;
      end
    end
    exp_index  = i;
    exp_tokens = exp_q.size();
  endtask

  // Monitor: count, stall stability and each transferred token against the model
  int   seen = 0;
  bit   prev_valid = 0;
  bit   prev_is_op = 0;
  int   prev_value = 0;
  bit   prev_xfer = 0;
  bit   xfer;
  tok_t got;
  always @(negedge clk) begin
    if (!rst) begin
      seen = 0; prev_valid = 0; prev_xfer = 0;
    end else begin
      checkOutput("tok_count_live", int'(tok_count), seen);
      if (prev_valid && !prev_xfer) begin
        checkOutput("stall_valid", int'(tok_valid), 1);
        checkOutput("stall_is_op", int'(tok_is_op), int'(prev_is_op));
        checkOutput("stall_value", int'(tok_value), prev_value);
      end
      if (tok_valid) checkOutput("valid_implies_busy", int'(busy), 1);
      xfer = tok_valid && tok_ready;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL extra_token actual=is_op:%0d/value:%0d required=none", tok_is_op, tok_value);
        end else begin
          got = exp_q.pop_front();
          checkOutput("token_is_op", int'(tok_is_op), int'(got.is_op));
          checkOutput("token_value", int'(tok_value), got.value);
        end
        seen++;
      end
      if (start && !busy) seen = 0;
      prev_valid = tok_valid;
      prev_is_op = tok_is_op;
      prev_value = int'(tok_value);
      prev_xfer  = xfer;
    end
  end

  // Run one scan; stall holds ready low for that many cycles per token, poke pulses start while busy
  task automatic applyStimulus(input int stall, input bit poke);
    int wait_cnt;
    int cyc;
    wait_cnt = 0; cyc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    tok_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b0;
    while (!(done || err) && cyc < 2000) begin
      if (tok_valid && wait_cnt < stall) begin
        tok_ready = 1'b0;
        wait_cnt++;
      end else begin
        tok_ready = 1'b1;
        wait_cnt = 0;
      end
      start = poke && tok_valid;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("scan_finished_in_budget", int'(cyc < 2000), 1);
  endtask

  task automatic checkScanEnd(input string tag);
    checkOutput({tag, "_done"}, int'(done), int'(!exp_err));
    checkOutput({tag, "_err"}, int'(err), int'(exp_err));
    checkOutput({tag, "_index"}, int'(index), exp_index);
    checkOutput({tag, "_tok_count"}, int'(tok_count), exp_tokens);
    checkOutput({tag, "_tokens_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    start = 1'b0;
    tok_ready = 1'b0;
    rom_src.delete();
    load_rom();

    #12;
    checkOutput("reset_tok_valid", int'(tok_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_index", int'(index), 0);
    checkOutput("reset_tok_count", int'(tok_count), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    $display("[TB] basic expression, ready always high");
    rom_src = '{1, 0, 23, 2, 10};
    load_rom();
    build_model();
    checkOutput("model_basic_size", exp_q.size(), 3);
    checkOutput("model_basic_t0", exp_q[0].value + 1000 * int'(exp_q[0].is_op), 10);
    checkOutput("model_basic_t1", exp_q[1].value + 1000 * int'(exp_q[1].is_op), 1023);
    checkOutput("model_basic_t2", exp_q[2].value + 1000 * int'(exp_q[2].is_op), 2);
    applyStimulus(0, 0);
    checkScanEnd("basic");
    checkOutput("basic_done_lit", int'(done), 1);
    checkOutput("basic_index_lit", int'(index), 4);
    checkOutput("basic_count_lit", int'(tok_count), 3);

    $display("[TB] same expression, 5-cycle stall per token, start poked while busy");
    build_model();
    applyStimulus(5, 1);
    checkScanEnd("stall");
    checkOutput("stall_index_lit", int'(index), 4);
    checkOutput("stall_count_lit", int'(tok_count), 3);

    $display("[TB] empty input");
    rom_src = '{10};
    load_rom();
    build_model();
    checkOutput("model_empty_size", exp_q.size(), 0);
    applyStimulus(0, 0);
    checkScanEnd("empty");
    checkOutput("empty_done_lit", int'(done), 1);
    checkOutput("empty_index_lit", int'(index), 0);
    checkOutput("empty_count_lit", int'(tok_count), 0);

    $display("[TB] overflow");
    rom_src = '{6, 5, 5, 3, 6, 10};
    load_rom();
    build_model();
    checkOutput("model_ovf_err", int'(exp_err), 1);
    checkOutput("model_ovf_index", exp_index, 4);
    applyStimulus(0, 0);
    checkScanEnd("ovf");
    checkOutput("ovf_err_lit", int'(err), 1);
    checkOutput("ovf_index_lit", int'(index), 4);
    checkOutput("ovf_count_lit", int'(tok_count), 0);

    $display("[TB] invalid code");
    rom_src = '{3, 15};
    load_rom();
    build_model();
    applyStimulus(0, 0);
    checkScanEnd("bad");
    checkOutput("bad_err_lit", int'(err), 1);
    checkOutput("bad_index_lit", int'(index), 1);
    checkOutput("bad_count_lit", int'(tok_count), 0);

    $display("[TB] reset while operator token is offered");
    rom_src = '{1, 0, 23, 2, 10};
    load_rom();
    build_model();
    @(posedge clk); #1;
    start = 1'b1;
    tok_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(tok_valid && tok_is_op) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    tok_ready = 1'b0;
    checkOutput("reached_emit_op", int'(tok_valid && tok_is_op), 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_tok_valid", int'(tok_valid), 0);
    checkOutput("async_rst_tok_is_op", int'(tok_is_op), 0);
    checkOutput("async_rst_tok_value", int'(tok_value), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_done", int'(done), 0);
    checkOutput("async_rst_err", int'(err), 0);
    checkOutput("async_rst_index", int'(index), 0);
    checkOutput("async_rst_tok_count", int'(tok_count), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    tok_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_stays_idle", int'(busy || tok_valid || done || err), 0);

    $display("[TB] leading operator after reset");
    rom_src = '{20, 7, 10};
    load_rom();
    build_model();
    checkOutput("model_lead_t0", exp_q[0].value + 1000 * int'(exp_q[0].is_op), 1020);
    checkOutput("model_lead_t1", exp_q[1].value + 1000 * int'(exp_q[1].is_op), 7);
    applyStimulus(0, 0);
    checkScanEnd("lead");
    checkOutput("lead_done_lit", int'(done), 1);
    checkOutput("lead_index_lit", int'(index), 2);

    $display("[TB] digit at last address");
    rom_src.delete();
    repeat (99) rom_src.push_back(0);
    rom_src.push_back(5);
    load_rom();
    build_model();
    applyStimulus(0, 0);
    checkScanEnd("last_digit");
    checkOutput("last_digit_err_lit", int'(err), 1);
    checkOutput("last_digit_index_lit", int'(index), 99);

    $display("[TB] end marker at last address");
    rom_src.delete();
    repeat (99) rom_src.push_back(0);
    rom_src.push_back(10);
    load_rom();
    build_model();
    applyStimulus(2, 0);
    checkScanEnd("last_end");
    checkOutput("last_end_done_lit", int'(done), 1);
    checkOutput("last_end_index_lit", int'(index), 99);
    checkOutput("last_end_count_lit", int'(tok_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/token_scanner.md
TOKEN_SCANNER -- requirements
Module: token_scanner

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset; asserted low clears all state immediately, independent of clk.
REQ-003 SHALL have port start  input  1  begin a scan from ROM address 0; honoured in IDLE, DONE and ERR only.
REQ-004 SHALL have port index  output  7  ROM address currently being read.
REQ-005 SHALL have port rom_data  input  8  token code returned combinationally by the ROM for index.
REQ-006 SHALL have port tok_valid  output  1  token on tok_* is valid.
REQ-007 SHALL have port tok_ready  input  1  downstream accepts token; transfer occurs when tok_valid and tok_ready are both high at a clk edge.
REQ-008 SHALL have port tok_is_op  output  1  1 = operator token, 0 = number token.
REQ-009 SHALL have port tok_value  output  16  unsigned number value when tok_is_op=0; raw operator code (zero-extended) when tok_is_op=1.
REQ-010 SHALL have port busy  output  1  high in FETCH, EMIT_NUM and EMIT_OP.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port err  output  1  high in ERR.
REQ-013 SHALL have port tok_count  output  7  number of tokens transferred in the current scan.

Function
REQ-014 SHALL interpret rom_data codes: 0-9 digit; 10 end marker '#'; 20-23 operator; all other codes invalid.
REQ-015 SHALL implement the states IDLE, FETCH, EMIT_NUM, EMIT_OP, DONE, ERR.
REQ-016 SHALL, on start in IDLE/DONE/ERR, enter FETCH next cycle with index=0, accumulator=0, have_num=0, tok_count=0.
REQ-017 SHALL, in FETCH on a digit, set acc <= acc*10 + digit, have_num <= 1, index <= index+1, and remain in FETCH (one digit per cycle).
REQ-018 SHALL, in FETCH on an operator, latch the code as pending_op, set index <= index+1, and go to EMIT_NUM if have_num=1, otherwise to EMIT_OP.
REQ-019 SHALL, in FETCH on '#', leave index unchanged and go to EMIT_NUM (end pending) if have_num=1, otherwise to DONE.
REQ-020 SHALL go to ERR, with index frozen at the offending address, on an invalid code.
REQ-021 SHALL go to ERR on accumulator overflow, i.e. when acc*10 + digit exceeds 65535.
REQ-022 SHALL go to ERR if a digit or operator is consumed at index=99; index SHALL never wrap past 99.
REQ-023 SHALL, in EMIT_NUM, drive tok_valid=1, tok_is_op=0, tok_value=acc, and on transfer clear acc and have_num, then go to EMIT_OP if an operator is pending or DONE if end is pending.
REQ-024 SHALL, in EMIT_OP, drive tok_valid=1, tok_is_op=1, tok_value=pending_op, and on transfer return to FETCH.
REQ-025 SHALL hold tok_is_op and tok_value stable, and keep tok_valid high, until transfer; tok_valid SHALL be 0 in all other states.
REQ-026 SHALL increment tok_count by 1 on each transfer.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL hold index, tok_count and state in DONE/ERR until start or reset.

Reset
REQ-029 SHALL, while rst=0, force state=IDLE, index=0, acc=0, have_num=0, pending flags=0, tok_count=0, and tok_valid=busy=done=err=0.
REQ-030 SHALL, on reset asserted mid-scan (including while tok_valid=1), abandon the token without transfer and restart only on a new start.

Verification
REQ-031 SHALL pass: ROM {1,0,23,2,10}, tok_ready=1 -> tokens NUM 10, OP 23, NUM 2; done=1, index=4, tok_count=3.
REQ-032 SHALL pass: same ROM with tok_ready low for 5 cycles on each token -> identical token sequence, tok_value stable while stalled, no duplicate or lost tokens.
REQ-033 SHALL pass: ROM {10} -> no token emitted; done=1, tok_count=0, index=0.
REQ-034 SHALL pass: ROM {6,5,5,3,6,10} -> err=1 at index=4, no token emitted; ROM {3,15} -> err=1 at index=1, no token emitted.
REQ-035 SHALL pass: rst driven low while EMIT_OP holds tok_valid=1 -> all outputs are 0 immediately; start after release rescans from index 0.
REQ-036 SHALL pass: ROM {20,7,10} -> tokens OP 20, NUM 7; done=1, index=2.
